// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the ID-stage hazard/flush controller.
package hazard_pkg;
  typedef enum logic {RUN, HOLD} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int LOAD_BR_STALL = 2;
  localparam int DEF_STALL = 1;
  function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (dest != REG_ZERO) && (dest == rs || (uses_rt && dest == rt));
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q;
  always_ff @(posedge clk)
    count_q <= reset ? '0 : (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  assign count = count_q;
endmodule

// File: rtl/hazard_flush_controller.sv
// hazard_flush_controller: load-use / branch-operand stall sequencing and IF/ID flush control.
module hazard_flush_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_is_jr,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_dest,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  state_t state_q, state_d;
  logic [1:0] hold_q, hold_d;
  logic [1:0] need;
  logic ex_match, mem_match, id_reads, stall;
  assign ex_match  = reg_match(ex_dest, id_rs, id_rt, id_uses_rt);
  assign mem_match = reg_match(mem_dest, id_rs, id_rt, id_uses_rt);
  assign id_reads  = id_is_branch || id_is_jr;
  always_comb
    need = (ex_mem_read && ex_match && id_reads)   ? 2'(LOAD_BR_STALL) :
           (ex_mem_read && ex_match)               ? 2'(DEF_STALL) :
           (ex_reg_write && ex_match && id_reads)  ? 2'(DEF_STALL) :
           (mem_mem_read && mem_match && id_reads) ? 2'(DEF_STALL) : 2'd0;
  always_ff @(posedge clk) begin
    state_q <= reset ? RUN : state_d;
    hold_q  <= reset ? 2'd0 : hold_d;
  end
  // HOLD finishes a multi-cycle stall blindly; hazards are not re-evaluated there.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stall   = 1'b0;
    if (state_q == HOLD) begin
      stall   = 1'b1;
      hold_d  = hold_q - 2'd1;
      state_d = (hold_q <= 2'd1) ? RUN : HOLD;
    end else if (need != 2'd0) begin
      stall = 1'b1;
      if (need == 2'(LOAD_BR_STALL)) begin
        hold_d  = 2'(LOAD_BR_STALL - 1);
        state_d = HOLD;
      end
    end
    if (reset) stall = 1'b0;
  end
  // ID/EX is held in reset alongside the controller so it leaves reset as a bubble.
  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign idex_flush = stall || reset;
  assign ifid_flush = (branch_taken || jump) && !stall && !reset;
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(stall), .count(stall_count));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(ifid_flush), .count(flush_count));
endmodule

// File: doc/hazard_flush_controller.md
# hazard_flush_controller

Producer side of the pipeline-register bubble/hold interface: decides each cycle whether PC and IF/ID hold, whether IF/ID is flushed, and whether ID/EX is zeroed through its synchronous active-high `reset` input. Sits in the ID stage, beside the control unit. It detects load-use and branch-operand hazards and sequences multi-cycle stalls with a small FSM and down-counter. It also keeps saturating stall/flush event counters for performance debug.

## Interface
- `CNT_W`, default 32: width of the event counters.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `id_rs`, `id_rt`  in  5: source register fields of the instruction in ID.
- `id_uses_rt`  in  1: the ID instruction reads `rt`. Low for I-type ALU ops and loads.
- `id_is_branch`  in  1: beq/bne in ID. Operands are compared in ID.
- `id_is_jr`  in  1: jr in ID. Reads `rs` in ID.
- `ex_mem_read`, `ex_reg_write`  in  1: MemRead and RegWrite of the instruction in EX.
- `ex_dest`  in  5: destination of the EX instruction after the RegDst mux. Holds 31 for jal.
- `mem_mem_read`  in  1: MemRead of the instruction in MEM.
- `mem_dest`  in  5: destination of the MEM instruction.
- `branch_taken`, `jump`  in  1: redirect resolved in ID this cycle.
- `pc_write`  out  1: PC load enable.
- `ifid_write`  out  1: IF/ID load enable.
- `ifid_flush`  out  1: zeroes IF/ID on the next edge.
- `idex_flush`  out  1: drives the ID/EX register `reset` and inserts a bubble.
- `stall_count`  out  CNT_W: cycles with a stall asserted.
- `flush_count`  out  CNT_W: cycles with `ifid_flush` asserted.

## Operation
- Match rule: `ex_match = (ex_dest != 0) && (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt))`. `mem_match` is defined the same way using `mem_dest`.
- Stall need, evaluated only in RUN; first matching row wins:
  - `ex_mem_read && ex_match && (id_is_branch || id_is_jr)` → 2 cycles.
  - `ex_mem_read && ex_match` → 1 cycle.
  - `ex_reg_write && ex_match && (id_is_branch || id_is_jr)` → 1 cycle.
  - `mem_mem_read && mem_match && (id_is_branch || id_is_jr)` → 1 cycle.
  - otherwise → 0.
- FSM states:
  - RUN: if need > 0, assert stall this cycle. If need = 2, load `hold_cnt` = 1 and go to HOLD; otherwise stay in RUN.
  - HOLD: assert stall and decrement `hold_cnt`. Return to RUN when `hold_cnt` reaches 0.
  - HOLD does not re-evaluate hazards.
- Stall outputs: `pc_write = 0`, `ifid_write = 0`, `idex_flush = 1`. Otherwise `pc_write = ifid_write = 1` and `idex_flush = 0`.
- Flush: `ifid_flush = (branch_taken || jump) && !stall`. A stall takes priority because branch operands are not yet valid.
- Counters:
  - `stall_count` increments on every cycle with stall asserted.
  - `flush_count` increments on every cycle with `ifid_flush` asserted.
  - Both saturate at all ones and never wrap.

## Timing
- Stall and flush outputs are combinational from the inputs and state. They take effect at the same clock edge at which the downstream registers sample.
- Latency from hazard to bubble: 0 cycles.
- Load-to-branch hazard: stall asserted for exactly 2 consecutive cycles.
- All other hazards: stall asserted for exactly 1 cycle.
- Reset values:
  - State RUN, `hold_cnt` = 0, both counters 0.
  - During reset the outputs are `pc_write = 1`, `ifid_write = 1`, `ifid_flush = 0`, `idex_flush = 1`.
- Reset asserted during HOLD returns the FSM to RUN on the next edge. The remaining stall cycles are discarded.
- Register $zero as a destination never causes a stall.
- A hazard and `branch_taken` in the same cycle produce a stall only: `ifid_flush = 0`.
- `jump` asserted while in HOLD is ignored.

## Structure
- Shared package `hazard_pkg`:
  - FSM state typedef `{RUN, HOLD}`.
  - Constant `REG_ZERO` = 5'd0.
  - Stall-length constants `LOAD_BR_STALL` = 2 and `DEF_STALL` = 1.
- Sub-module `sat_counter` (parameter `CNT_W`; ports clk, reset, inc, count), instantiated twice.

## Test plan
- `ex_mem_read=1`, `ex_dest=8`, `id_rs=8`, no branch → one cycle with `pc_write=0`, `ifid_write=0`, `idex_flush=1`; `stall_count=1`.
- `ex_mem_read=1`, `ex_dest=9`, `id_rt=9`, `id_uses_rt=1`, `id_is_branch=1` → stall on 2 consecutive cycles, then RUN; `stall_count=2`.
- `ex_reg_write=1`, `ex_dest=0`, `id_rs=0`, `id_is_branch=1` → no stall.
- `branch_taken=1` with no hazard → `ifid_flush=1` for one cycle, `flush_count=1`. Same stimulus with a concurrent load-use hazard → `ifid_flush=0`.
- Enter HOLD, assert reset on the next cycle → the following cycle is in RUN with stall deasserted and both counters 0.
- Force `stall_count` to all ones with `CNT_W=4` (15 stalls), apply one more stall → count stays 15.
